row_chunk_feeder: RTL and testbench
===================================

Name: row_chunk_feeder

Overview:
Upstream stage of row_by_vector_with_control. Streams one matrix row at a time, as NI-element chunks, from the row memory (A) and the vector memory (P) into the dot-product stage. Paces chunk delivery from that stage's give_me_only request and waits for its decoder_read_now completion pulse before advancing to the next row. Runs all rows of one matrix-by-vector pass per go pulse.

Parameters:
NI, 8, elements per chunk; must match the dot-product stage
ELEMENT_WIDTH, 32, bits per element (IEEE single)
ADDR_WIDTH, 12, chunk address width of both memories
CNT_WIDTH, 16, width of row and chunk counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
go  input  1  one-cycle pulse; starts a pass when in IDLE, ignored otherwise
no_of_rows  input  CNT_WIDTH  rows in the pass; latched on go
no_of_multiples  input  32  chunks per row; latched on go; only low CNT_WIDTH bits used
a_addr  output  ADDR_WIDTH  A memory chunk address
p_addr  output  ADDR_WIDTH  P memory chunk address
mem_rd_en  output  1  read strobe for both memories
a_rdata  input  NI*ELEMENT_WIDTH  A read data, valid 1 cycle after mem_rd_en
p_rdata  input  NI*ELEMENT_WIDTH  P read data, valid 1 cycle after mem_rd_en
a  output  NI*ELEMENT_WIDTH  registered row chunk to the dot-product stage
p  output  NI*ELEMENT_WIDTH  registered vector chunk to the dot-product stage
start_row_by_vector  output  1  one-cycle pulse together with chunk 0 of each row
you_can_read  output  1  one-cycle pulse; a and p hold a valid chunk
no_of_multiples_out  output  32  latched chunks-per-row value
give_me_only  input  1  dot-product stage requests the next chunk
decoder_read_now  input  1  dot-product stage finished the row result
I_am_ready  input  1  dot-product stage can accept a new row
row_index  output  CNT_WIDTH  current row, 0-based
busy  output  1  high from the cycle after go until done
done  output  1  one-cycle pulse when the pass completes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0. Reset mid-pass aborts immediately; no further you_can_read or done is produced.
- Addressing: a_addr = row*M + chunk, computed incrementally (row base register += M per row, no multiplier); p_addr = chunk. M = latched no_of_multiples. Both truncate to ADDR_WIDTH (wrap).
- FSM states:
  - IDLE: on go, latch no_of_rows and M, clear counters. If no_of_rows==0 or M==0, go to DONE; else go to ISSUE.
  - ISSUE: mem_rd_en=1 for one cycle with current addresses; go to CAPTURE.
  - CAPTURE: load a<=a_rdata, p<=p_rdata; go to PRESENT.
  - PRESENT: if chunk==0 and I_am_ready==0, stall here. Otherwise pulse you_can_read, and pulse start_row_by_vector as well when chunk==0. If chunk==M-1, go to ROW_WAIT; else go to REQ_WAIT.
  - REQ_WAIT: on give_me_only, chunk++ and go to ISSUE.
  - ROW_WAIT: on decoder_read_now, row++, chunk=0 and row base += M. If row was no_of_rows-1, go to DONE; else go to ISSUE.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- a and p hold their value until the next CAPTURE.
- Latency: go to first you_can_read is 4 cycles (IDLE, ISSUE, CAPTURE, PRESENT) when I_am_ready=1. give_me_only to the next you_can_read is 3 cycles.
- give_me_only outside REQ_WAIT is ignored. decoder_read_now outside ROW_WAIT is ignored.
- M==1: every row goes PRESENT to ROW_WAIT; give_me_only is never required.
- go while busy: ignored. go and reset in the same cycle: reset wins.

Optional Feature:
ROW_FEEDER_STALL_CNT_EN
- Defined: adds output stall_cycles (32 bits). It counts every cycle spent in REQ_WAIT, ROW_WAIT, or PRESENT-stalled, clears on go, holds after done, and saturates at all-ones.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- no_of_rows=2, M=3, give_me_only 2 cycles after each you_can_read, decoder_read_now 5 cycles after the last chunk -> a_addr sequence 0,1,2,3,4,5; p_addr sequence 0,1,2,0,1,2; 6 you_can_read pulses; start_row_by_vector with chunks 0 and 3; done once.
- no_of_rows=3, M=1 -> no give_me_only needed; a_addr 0,1,2; 3 start pulses; row_index 0,1,2; done after the third decoder_read_now.
- no_of_rows=0 or M=0 -> done 2 cycles after go; mem_rd_en never asserted.
- I_am_ready held low 10 cycles at chunk 0 -> you_can_read delayed exactly 10 cycles; a and p stable throughout.
- Reset asserted in REQ_WAIT of row 1 -> all outputs 0 the next cycle; a fresh go restarts at a_addr 0.
- ROW_FEEDER_STALL_CNT_EN defined, first scenario -> stall_cycles = 2*4 (REQ_WAIT) + 2*5 (ROW_WAIT) = 18.

Source files
------------

// File: rtl/row_chunk_feeder.sv
// Streams one matrix row at a time, as NI-element chunks of A and P, into the dot-product stage.
// Latency: go -> first you_can_read in 4 cycles; give_me_only -> next you_can_read in 3 cycles.
// Backpressure: chunk 0 held while I_am_ready=0; later chunks wait for give_me_only; next row waits for decoder_read_now.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   go                    one-cycle start pulse (ignored unless idle)
//   no_of_rows            rows in the pass, latched on go
//   no_of_multiples       chunks per row (M), latched on go, low CNT_WIDTH bits used
//   a_addr, p_addr        chunk addresses for A (row*M+chunk) and P (chunk)
//   mem_rd_en             read strobe for both memories, data returns one cycle later
//   a_rdata, p_rdata      memory read data
//   a, p                  registered chunk presented to the dot-product stage
//   start_row_by_vector   pulse alongside chunk 0 of every row
//   you_can_read          pulse: a and p hold a valid chunk
//   no_of_multiples_out   latched chunks-per-row value
//   give_me_only          dot-product stage asks for the next chunk
//   decoder_read_now      dot-product stage has consumed the row result
//   I_am_ready            dot-product stage can accept a new row
//   row_index             current row, 0-based
//   busy, done            pass in progress / one-cycle completion pulse
//   stall_cycles          only when ROW_FEEDER_STALL_CNT_EN is defined: saturating count of
//                         cycles spent waiting on the dot-product stage during the pass

module row_chunk_feeder #(
    parameter int NI            = 8,
    parameter int ELEMENT_WIDTH = 32,
    parameter int ADDR_WIDTH    = 12,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic [CNT_WIDTH-1:0]          no_of_rows,
    input  logic [31:0]                   no_of_multiples,
    output logic [ADDR_WIDTH-1:0]         a_addr,
    output logic [ADDR_WIDTH-1:0]         p_addr,
    output logic                          mem_rd_en,
    input  logic [NI*ELEMENT_WIDTH-1:0]   a_rdata,
    input  logic [NI*ELEMENT_WIDTH-1:0]   p_rdata,
    output logic [NI*ELEMENT_WIDTH-1:0]   a,
    output logic [NI*ELEMENT_WIDTH-1:0]   p,
    output logic                          start_row_by_vector,
    output logic                          you_can_read,
    output logic [31:0]                   no_of_multiples_out,
    input  logic                          give_me_only,
    input  logic                          decoder_read_now,
    input  logic                          I_am_ready,
    output logic [CNT_WIDTH-1:0]          row_index,
    output logic                          busy,
    output logic                          done
`ifdef ROW_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    localparam int DW = NI * ELEMENT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_PRESENT,
        S_REQ_WAIT,
        S_ROW_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    rows_q, rows_d;
    logic [31:0]             mult_q, mult_d;
    logic [CNT_WIDTH-1:0]    row_q, row_d;
    logic [CNT_WIDTH-1:0]    chunk_q, chunk_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [DW-1:0]           a_q, a_d;
    logic [DW-1:0]           p_q, p_d;

    logic [CNT_WIDTH-1:0]    m_lo;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic                    chunk_zero;
    logic                    chunk_last;
    logic                    row_last;
    logic                    rd_en_c;
    logic                    ycr_c;
    logic                    start_c;
    logic                    done_c;

    // Only the low CNT_WIDTH bits of M take part in counting and addressing.
    assign m_lo       = mult_q[CNT_WIDTH-1:0];
    assign m_addr     = ADDR_WIDTH'(m_lo);
    assign chunk_zero = (chunk_q == '0);
    assign chunk_last = (chunk_q == m_lo - CNT_WIDTH'(1));
    assign row_last   = (row_q == rows_q - CNT_WIDTH'(1));

    // Next-state and per-state strobes.
    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        mult_d  = mult_q;
        row_d   = row_q;
        chunk_d = chunk_q;
        base_d  = base_q;
        a_d     = a_q;
        p_d     = p_q;
        rd_en_c = 1'b0;
        ycr_c   = 1'b0;
        start_c = 1'b0;
        done_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    rows_d  = no_of_rows;
                    mult_d  = no_of_multiples;
                    row_d   = '0;
                    chunk_d = '0;
                    base_d  = '0;
                    // Empty pass: nothing to read, finish straight away.
                    if ((no_of_rows == '0) || (no_of_multiples[CNT_WIDTH-1:0] == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                rd_en_c = 1'b1;
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                a_d     = a_rdata;
                p_d     = p_rdata;
                state_d = S_PRESENT;
            end

            S_PRESENT: begin
                // A new row may only start once the dot-product stage is ready;
                // mid-row chunks are already paced by give_me_only.
                if (!(chunk_zero && !I_am_ready)) begin
                    ycr_c   = 1'b1;
                    start_c = chunk_zero;
                    if (chunk_last) begin
                        state_d = S_ROW_WAIT;
                    end else begin
                        state_d = S_REQ_WAIT;
                    end
                end
            end

            S_REQ_WAIT: begin
                if (give_me_only) begin
                    chunk_d = chunk_q + CNT_WIDTH'(1);
                    state_d = S_ISSUE;
                end
            end

            S_ROW_WAIT: begin
                if (decoder_read_now) begin
                    row_d   = row_q + CNT_WIDTH'(1);
                    chunk_d = '0;
                    // Row base advances by M instead of multiplying row*M.
                    base_d  = base_q + m_addr;
                    if (row_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            mult_q  <= '0;
            row_q   <= '0;
            chunk_q <= '0;
            base_q  <= '0;
            a_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            mult_q  <= mult_d;
            row_q   <= row_d;
            chunk_q <= chunk_d;
            base_q  <= base_d;
            a_q     <= a_d;
            p_q     <= p_d;
        end
    end

    // Addresses wrap at ADDR_WIDTH bits.
    assign a_addr              = base_q + ADDR_WIDTH'(chunk_q);
    assign p_addr              = ADDR_WIDTH'(chunk_q);
    assign mem_rd_en           = rd_en_c;
    assign a                   = a_q;
    assign p                   = p_q;
    assign start_row_by_vector = start_c;
    assign you_can_read        = ycr_c;
    assign no_of_multiples_out = mult_q;
    assign row_index           = row_q;
    assign busy                = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done                = done_c;

`ifdef ROW_FEEDER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_now;

    // Waiting cycles: chunk request, row completion, or a row start held off by I_am_ready.
    always_comb begin
        stall_now = (state_q == S_REQ_WAIT) || (state_q == S_ROW_WAIT) ||
                    ((state_q == S_PRESENT) && chunk_zero && !I_am_ready);
        stall_d   = stall_q;
        if ((state_q == S_IDLE) && go) begin
            stall_d = '0;
        end else if (stall_now && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_row_chunk_feeder.sv
// Bench for row_chunk_feeder: table of directed passes with hand-computed timing and addresses,
// plus a hand-written mid-pass reset sequence.
module tb_row_chunk_feeder;

    localparam int NI = 8;
    localparam int EW = 32;
    localparam int AW = 12;
    localparam int CW = 16;
    localparam int DW = NI * EW;

    logic            clk;
    logic            reset;
    logic            go;
    logic [CW-1:0]   no_of_rows;
    logic [31:0]     no_of_multiples;
    logic [AW-1:0]   a_addr;
    logic [AW-1:0]   p_addr;
    logic            mem_rd_en;
    logic [DW-1:0]   a_rdata;
    logic [DW-1:0]   p_rdata;
    logic [DW-1:0]   a;
    logic [DW-1:0]   p;
    logic            start_row_by_vector;
    logic            you_can_read;
    logic [31:0]     no_of_multiples_out;
    logic            give_me_only;
    logic            decoder_read_now;
    logic            I_am_ready;
    logic [CW-1:0]   row_index;
    logic            busy;
    logic            done;
`ifdef ROW_FEEDER_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    row_chunk_feeder #(.NI(NI), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .go                  (go),
        .no_of_rows          (no_of_rows),
        .no_of_multiples     (no_of_multiples),
        .a_addr              (a_addr),
        .p_addr              (p_addr),
        .mem_rd_en           (mem_rd_en),
        .a_rdata             (a_rdata),
        .p_rdata             (p_rdata),
        .a                   (a),
        .p                   (p),
        .start_row_by_vector (start_row_by_vector),
        .you_can_read        (you_can_read),
        .no_of_multiples_out (no_of_multiples_out),
        .give_me_only        (give_me_only),
        .decoder_read_now    (decoder_read_now),
        .I_am_ready          (I_am_ready),
        .row_index           (row_index),
        .busy                (busy),
        .done                (done)
`ifdef ROW_FEEDER_STALL_CNT_EN
        ,
        .stall_cycles        (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents encode tag, element index and address so every chunk is distinct.
    function automatic logic [DW-1:0] amem(input logic [AW-1:0] ad);
        logic [DW-1:0] r;
        for (int e = 0; e < NI; e++) r[e*EW +: EW] = {8'hA5, 4'(e), 8'h00, ad};
        return r;
    endfunction

    function automatic logic [DW-1:0] pmem(input logic [AW-1:0] ad);
        logic [DW-1:0] r;
        for (int e = 0; e < NI; e++) r[e*EW +: EW] = {8'h5C, 4'(e), 8'h11, ad};
        return r;
    endfunction

    // Synchronous-read memories: data one cycle after mem_rd_en.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            a_rdata <= amem(a_addr);
            p_rdata <= pmem(p_addr);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        int               rows;
        int               mult;
        int               ready_low;   // cycles I_am_ready held low starting at cycle 3
        int               gap_g;       // you_can_read -> give_me_only distance
        int               gap_d;       // last you_can_read -> decoder_read_now distance
        int               noise;       // hold give_me_only high all pass
        int               go2;         // cycle of an extra go while busy (0 = none)
        int               nrd;         // expected reads == expected you_can_read pulses
        logic [7:0][11:0] ea;          // expected a_addr per read
        logic [7:0][11:0] ep;          // expected p_addr per read
        logic [7:0][15:0] er;          // expected row_index per you_can_read
        logic [7:0]       es;          // expected start_row_by_vector per you_can_read
        int               first;       // cycle of first you_can_read (go = cycle 0)
        int               dn;          // cycle of done
        int               st;          // expected stall count
    } vec_t;

    function automatic vec_t mk(input int rows, mult, rlow, gg, gd, noise, go2, nrd,
                                input logic [7:0][11:0] ea, ep, input logic [7:0][15:0] er,
                                input logic [7:0] es, input int first, dn, st);
        vec_t v;
        v.rows = rows; v.mult = mult; v.ready_low = rlow; v.gap_g = gg; v.gap_d = gd;
        v.noise = noise; v.go2 = go2; v.nrd = nrd; v.ea = ea; v.ep = ep; v.er = er;
        v.es = es; v.first = first; v.dn = dn; v.st = st;
        return v;
    endfunction

    task automatic run_pass(input vec_t v, input int abort_at);
        int k, nrd, ndone, g_at, d_at, mlo;
        logic busy_bad;
        k = 0; nrd = 0; ndone = 0; g_at = -1; d_at = -1; busy_bad = 1'b0;
        mlo = v.mult & 32'h0000_FFFF;
        for (int c = 0; c < v.dn + 4; c++) begin
            @(posedge clk); #1;
            go               = (c == 0) || (v.go2 != 0 && c == v.go2);
            no_of_rows       = (v.go2 != 0 && c == v.go2) ? 16'd7 : 16'(v.rows);
            no_of_multiples  = (v.go2 != 0 && c == v.go2) ? 32'd9 : v.mult;
            give_me_only     = (v.noise != 0) || (c == g_at);
            decoder_read_now = (c == d_at);
            I_am_ready       = !(c >= 3 && c < 3 + v.ready_low);
            reset            = (abort_at > 0 && c == abort_at);
            @(negedge clk);
            if (reset) return;
            if (mem_rd_en) begin
                if (nrd < 8) begin
                    chk("a_addr", DW'(a_addr), DW'(v.ea[nrd[2:0]]));
                    chk("p_addr", DW'(p_addr), DW'(v.ep[nrd[2:0]]));
                end
                nrd++;
            end
            if (!I_am_ready && c >= 3) begin
                chk("stall_ycr", DW'(you_can_read), DW'(1'b0));
                chk("stall_a", a, amem(v.ea[0]));
                chk("stall_p", p, pmem(v.ep[0]));
            end
            if (you_can_read) begin
                if (k < 8) begin
                    chk("start", DW'(start_row_by_vector), DW'(v.es[k[2:0]]));
                    chk("row_index", DW'(row_index), DW'(v.er[k[2:0]]));
                    chk("a_data", a, amem(v.ea[k[2:0]]));
                    chk("p_data", p, pmem(v.ep[k[2:0]]));
                end
                if (k == 0) chk("first_ycr_cycle", DW'(c), DW'(v.first));
                if (mlo != 0 && ((k + 1) % mlo) != 0) g_at = c + v.gap_g;
                else d_at = c + v.gap_d;
                k++;
            end
            if (done) begin
                ndone++;
                chk("done_cycle", DW'(c), DW'(v.dn));
            end
            if (busy !== (c >= 1 && c < v.dn)) busy_bad = 1'b1;
        end
        go = 1'b0; give_me_only = 1'b0; decoder_read_now = 1'b0; I_am_ready = 1'b1;
        chk("num_reads", DW'(nrd), DW'(v.nrd));
        chk("num_ycr", DW'(k), DW'(v.nrd));
        chk("num_done", DW'(ndone), DW'(1));
        chk("busy_window", DW'(busy_bad), DW'(1'b0));
        chk("mult_out", DW'(no_of_multiples_out), DW'(v.mult));
`ifdef ROW_FEEDER_STALL_CNT_EN
        chk("stall_cycles", DW'(stall_cycles), DW'(v.st));
`endif
    endtask

    vec_t vecs [5];

    initial begin
        int nev;
        // rows, M, ready_low, gap_g, gap_d, noise, go2, nreads, a_addr, p_addr, rows, starts, first, done, stall
        vecs[0] = mk(2, 3, 0, 2, 5, 0, 10, 6,
                     {12'd0, 12'd0, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0},
                     {12'd0, 12'd0, 12'd2, 12'd1, 12'd0, 12'd2, 12'd1, 12'd0},
                     {16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0},
                     8'b0000_1001, 3, 37, 18);
        vecs[1] = mk(3, 1, 0, 0, 1, 1, 6, 3,
                     {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd2, 12'd1, 12'd0},
                     '0,
                     {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd1, 16'd0},
                     8'b0000_0111, 3, 13, 3);
        vecs[2] = mk(0, 3, 0, 0, 0, 0, 0, 0, '0, '0, '0, 8'b0, 0, 1, 0);
        vecs[3] = mk(2, 32'h0001_0000, 0, 0, 0, 0, 0, 0, '0, '0, '0, 8'b0, 0, 1, 0);
        vecs[4] = mk(1, 2, 10, 1, 2, 0, 0, 2,
                     {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd0},
                     {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd0},
                     '0, 8'b0000_0001, 13, 20, 13);

        reset = 1'b1; go = 1'b0; no_of_rows = '0; no_of_multiples = '0;
        give_me_only = 1'b0; decoder_read_now = 1'b0; I_am_ready = 1'b1;
        a_rdata = '0; p_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_done", DW'(done), DW'(1'b0));
        chk("rst_rd_en", DW'(mem_rd_en), DW'(1'b0));
        chk("rst_a", a, '0);
        chk("rst_a_addr", DW'(a_addr), DW'(0));
        chk("rst_row", DW'(row_index), DW'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_pass(vecs[i], 0);

        // Reset in REQ_WAIT of row 1 (cycle 22), then go and reset together.
        run_pass(vecs[0], 22);
        @(posedge clk); #1;
        reset = 1'b1; go = 1'b1;
        @(negedge clk);
        chk("abort_busy", DW'(busy), DW'(1'b0));
        chk("abort_rd_en", DW'(mem_rd_en), DW'(1'b0));
        chk("abort_a_addr", DW'(a_addr), DW'(0));
        chk("abort_p_addr", DW'(p_addr), DW'(0));
        chk("abort_a", a, '0);
        chk("abort_p", p, '0);
        chk("abort_row", DW'(row_index), DW'(0));
        chk("abort_mult", DW'(no_of_multiples_out), DW'(0));
        chk("abort_ycr", DW'(you_can_read), DW'(1'b0));
        @(posedge clk); #1;
        reset = 1'b0; go = 1'b0;
        @(negedge clk);
        chk("go_with_reset_ignored", DW'(busy), DW'(1'b0));
        nev = 0;
        repeat (6) begin
            @(negedge clk);
            if (you_can_read || done || mem_rd_en) nev++;
        end
        chk("quiet_after_abort", DW'(nev), DW'(0));

        // Fresh pass after the abort starts again from a_addr 0.
        run_pass(vecs[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
